// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state encoding and default parameter values
// for the register-file scoreboard.
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;

endpackage

`default_nettype wire

// File: rtl/regfile_if.sv
// regfile_if: write/reserve/clear/read bundle of the register-file scoreboard.
`default_nettype none

interface regfile_if import regfile_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD
) ();
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     resv_en;
    logic [ADDR_W-1:0]        resv_addr;
    logic                     clr_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     init_done;

    modport master (
        output wr_en, wr_addr, wr_data, resv_en, resv_addr, clr_req, rd_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, resv_en, resv_addr, clr_req, rd_addr,
        output rd_data, rd_busy, init_done
    );

endinterface

`default_nettype wire

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read mux with register-0 and
// clear-masking; optional write forwarding under REGFILE_BYPASS_EN.
`default_nettype none

module regfile_read_port #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  wire logic                             active,
    input  wire logic [ADDR_W-1:0]                addr,
    input  wire logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  wire logic [NUM_REGS-1:0]              pending,
    input  wire logic                             wr_en,
    input  wire logic [ADDR_W-1:0]                wr_addr,
    input  wire logic [DATA_W-1:0]                wr_data,
    input  wire logic                             resv_en,
    input  wire logic [ADDR_W-1:0]                resv_addr,
    output logic      [DATA_W-1:0]                data,
    output logic                                  busy
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (active && addr != '0) begin
            data = regs[addr];
            busy = pending[addr];
            // An in-flight write completes the reservation unless it is re-reserved now
            if (wr_en && wr_addr == addr) begin
                data = wr_data;
                busy = resv_en && (resv_addr == addr);
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = &{1'b0, wr_en, wr_addr, wr_data, resv_en, resv_addr};

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (active && addr != '0) begin
            data = regs[addr];
            busy = pending[addr];
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-entry pending bits and a
// one-entry-per-cycle zero sweep; REGFILE_BYPASS_EN enables write forwarding.
`default_nettype none

module regfile_scoreboard import regfile_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD
) (
    input  wire logic clk,
    input  wire logic rst,
    regfile_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    state_t                       state, state_n;
    logic [ADDR_W-1:0]            sweep_idx, sweep_idx_n;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]          pending;
    logic                         active;

    assign active        = (state == IDLE);
    assign bus.init_done = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            sweep_idx <= '0;
        end else begin
            state     <= state_n;
            sweep_idx <= sweep_idx_n;
        end
    end

    always_comb begin
        state_n     = state;
        sweep_idx_n = sweep_idx;
        case (state)
            CLEAR: begin
                sweep_idx_n = sweep_idx + 1'b1;
                if (sweep_idx == ADDR_W'(NUM_REGS - 1)) begin
                    state_n     = IDLE;
                    sweep_idx_n = '0;
                end
            end
            IDLE: begin
                if (bus.clr_req) begin
                    state_n     = CLEAR;
                    sweep_idx_n = '0;
                end
            end
            default: begin
                state_n     = CLEAR;
                sweep_idx_n = '0;
            end
        endcase
    end

    // Storage has no reset of its own: the sweep zeroes it while reads are masked
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[sweep_idx]    <= '0;
                pending[sweep_idx] <= 1'b0;
            end else begin
                if (bus.wr_en && bus.wr_addr != '0) begin
                    regs[bus.wr_addr]    <= bus.wr_data;
                    pending[bus.wr_addr] <= 1'b0;
                end
                if (bus.resv_en && bus.resv_addr != '0) begin
                    pending[bus.resv_addr] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS),
                .ADDR_W   (ADDR_W)
            ) u_rd (
                .active    (active),
                .addr      (bus.rd_addr[p*ADDR_W +: ADDR_W]),
                .regs      (regs),
                .pending   (pending),
                .wr_en     (bus.wr_en),
                .wr_addr   (bus.wr_addr),
                .wr_data   (bus.wr_data),
                .resv_en   (bus.resv_en),
                .resv_addr (bus.resv_addr),
                .data      (bus.rd_data[p*DATA_W +: DATA_W]),
                .busy      (bus.rd_busy[p])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter NUM_REGS, default 32, register count (power of two, >=4).
REQ-003 SHALL provide parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL derive localparam ADDR_W = $clog2(NUM_REGS).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  ADDR_W  write index.
REQ-009 wr_data  input  DATA_W  write value.
REQ-010 resv_en  input  1  mark destination register pending.
REQ-011 resv_addr  input  ADDR_W  index to mark pending.
REQ-012 clr_req  input  1  request full zero-sweep of the array.
REQ-013 rd_addr  input  NUM_RD*ADDR_W  packed read indices, port 0 in LSBs.
REQ-014 rd_data  output  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
REQ-015 rd_busy  output  NUM_RD  per-port pending flag of addressed register.
REQ-016 init_done  output  1  high when array is cleared and accepting traffic.

Function
REQ-017 SHALL implement FSM with states CLEAR and IDLE.
REQ-018 In CLEAR, SHALL write zero to one entry per cycle at sweep index 0..NUM_REGS-1 and clear its pending bit; exactly NUM_REGS cycles.
REQ-019 SHALL transition CLEAR->IDLE on the cycle after index NUM_REGS-1 is cleared; init_done rises with IDLE.
REQ-020 In IDLE, clr_req SHALL transition to CLEAR with sweep index 0 on next edge; clr_req in CLEAR SHALL be ignored (no restart).
REQ-021 In CLEAR, wr_en and resv_en SHALL be ignored; rd_data SHALL read 0 and rd_busy SHALL read 0 on all ports.
REQ-022 In IDLE, wr_en SHALL store wr_data at wr_addr and clear pending[wr_addr] at the edge.
REQ-023 In IDLE, resv_en SHALL set pending[resv_addr] at the edge.
REQ-024 wr_en and resv_en to the same address in one cycle: data SHALL be written and pending SHALL end set (reservation wins).
REQ-025 Register 0 SHALL always read 0 with rd_busy 0; writes and reservations to index 0 SHALL be dropped.
REQ-026 Read ports SHALL be fully independent; any ports may address the same register.
REQ-027 rd_busy[p] SHALL equal pending[rd_addr[p]] (subject to REQ-033).

Reset
REQ-028 rst SHALL force state CLEAR, sweep index 0, init_done 0 on the next edge, overriding all other inputs.
REQ-029 rst asserted mid-sweep SHALL restart the sweep at index 0.
REQ-030 All pending bits SHALL be 0 once the sweep completes; array contents before completion SHALL be unobservable (REQ-021).
REQ-031 No initial blocks SHALL be relied upon for reset values.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-033 With REGFILE_BYPASS_EN defined: in IDLE, a read port whose rd_addr equals wr_addr (nonzero) while wr_en is high SHALL return wr_data, and rd_busy SHALL return 0 unless resv_en targets the same address that cycle.
REQ-034 Without REGFILE_BYPASS_EN: reads SHALL return the pre-edge stored value and pre-edge pending bit.

Structure
REQ-035 Shared package regfile_pkg SHALL hold the FSM state enum (CLEAR, IDLE) and default-parameter constants.
REQ-036 One sub-module regfile_read_port SHALL implement a single read mux plus bypass/zero logic, instantiated NUM_RD times via generate.

Verification
REQ-037 rst 1 cycle then idle -> init_done low exactly 32 cycles, then high; all 32 registers read 0, rd_busy 0.
REQ-038 Write 0xDEADBEEF to r5, read r5 on ports 0 and 1 next cycle -> both 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-039 resv_en r7 -> rd_busy 1 for r7; later wr_en r7=0x55 -> rd_busy 0, data 0x55; same-cycle wr and resv to r9 -> busy 1, data updated.
REQ-040 Bypass build: wr_en r3=0xA5A5A5A5 with rd_addr r3 same cycle -> rd_data 0xA5A5A5A5; non-bypass build -> old value 0.
REQ-041 rst asserted at sweep index 10 -> sweep restarts, init_done rises 32 cycles after rst deasserts; wr_en during CLEAR leaves target 0.
REQ-042 clr_req in IDLE after writing r4=0x77, r4 pending -> CLEAR 32 cycles, then r4 reads 0, busy 0; second clr_req mid-sweep does not extend it.
